// File: rtl/timer_run_ctrl.sv
// rtl/timer_run_ctrl.sv - run/pause/clear sequencer for the HH:MM:SS digit counter
//
// Purpose: turns the start/stop and clear button levels into single edge
// events, runs the IDLE/RUN/PAUSE/DONE sequencer, and generates the 1 Hz
// count tick, the blink tick and a one-cycle clear for the digit counter.
// Optionally stops the count when the counter reaches a programmed limit.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   btn_ss       start/stop button level (debounced, async to clk)
//   btn_clr      clear button level (debounced, async to clk)
//   limit_en     enables the limit compare
//   limit        limit time, BCD {hr1,hr0,min1,min0,sec1,sec0}
//   cur_time     counter digits, same packing as limit
//   start        count enable level (high in RUN)
//   clken        one-cycle tick every CLK_DIV RUN cycles
//   blink_en     one-cycle tick every BLINK_DIV RUN cycles
//   timer_clr_n  active-low one-cycle clear to the counter
//   done         high while in DONE
//   state        IDLE=0, RUN=1, PAUSE=2, DONE=3

module timer_run_ctrl #(
  parameter int CLK_DIV   = 100000000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_ss,
  input  logic        btn_clr,
  input  logic        limit_en,
  input  logic [23:0] limit,
  input  logic [23:0] cur_time,
  output logic        start,
  output logic        clken,
  output logic        blink_en,
  output logic        timer_clr_n,
  output logic        done,
  output logic [1:0]  state
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_clr_req;

  logic            r_ss_s1, r_ss_s2, r_ss_d;
  logic            r_clr_s1, r_clr_s2, r_clr_d;
  logic            w_ss_evt, w_clr_evt, w_match;

  logic [PW-1:0]   r_pre;
  logic [BW-1:0]   r_blink;
  logic            r_clken, r_blink_en, r_clr_n;

  // Two-stage synchronizer followed by a delay stage; the event is the
  // rising edge of the synchronized level, so a held button fires once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ss_s1  <= 1'b0;
      r_ss_s2  <= 1'b0;
      r_ss_d   <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
      r_clr_d  <= 1'b0;
    end else begin
      r_ss_s1  <= btn_ss;
      r_ss_s2  <= r_ss_s1;
      r_ss_d   <= r_ss_s2;
      r_clr_s1 <= btn_clr;
      r_clr_s2 <= r_clr_s1;
      r_clr_d  <= r_clr_s2;
    end
  end

  assign w_ss_evt  = r_ss_s2 & ~r_ss_d;
  assign w_clr_evt = r_clr_s2 & ~r_clr_d;
  assign w_match   = limit_en & (cur_time == limit) & (r_state == ST_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear wins over start/stop outside RUN; inside RUN the limit match
  // wins over start/stop and clear is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_evt) begin
          w_clr_req = 1'b1;
        end else if (w_ss_evt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_match) begin
          w_state_nxt = ST_DONE;
        end else if (w_ss_evt) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_clr_evt) begin
          w_state_nxt = ST_IDLE;
          w_clr_req   = 1'b1;
        end else if (w_ss_evt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_clr_evt) begin
          w_state_nxt = ST_IDLE;
          w_clr_req   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Prescaler and blink counter: cleared in IDLE, advance only in RUN and
  // hold in PAUSE/DONE so a resumed run keeps its partial second. The
  // ticks are registered, so the first one lands CLK_DIV cycles after
  // start rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre      <= '0;
      r_blink    <= '0;
      r_clken    <= 1'b0;
      r_blink_en <= 1'b0;
      r_clr_n    <= 1'b1;
    end else begin
      r_clken    <= 1'b0;
      r_blink_en <= 1'b0;
      r_clr_n    <= ~w_clr_req;
      if (r_state == ST_IDLE) begin
        r_pre   <= '0;
        r_blink <= '0;
      end else if (r_state == ST_RUN) begin
        if (r_pre == PRE_MAX) begin
          r_pre   <= '0;
          r_clken <= 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
        if (r_blink == BLINK_MAX) begin
          r_blink    <= '0;
          r_blink_en <= 1'b1;
        end else begin
          r_blink <= r_blink + 1'b1;
        end
      end
    end
  end

  assign start       = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign state       = r_state;
  assign clken       = r_clken;
  assign blink_en    = r_blink_en;
  assign timer_clr_n = r_clr_n;

endmodule
